// File: rtl/spi_flash_mmio.sv
// Read-only MMIO window onto SPI NOR flash: one READ (0x03) per CPU word read, wakes flash after reset.
// Latency: memReady pulses 2 + 128*CLK_DIV clk cycles after the request is accepted.
// Backpressure: the CPU holds memRead until memReady; requests wait while waking or busy.
module spi_flash_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] WINDOW_BYTES = 32'h0010_0000,
  parameter logic [23:0] FLASH_OFFSET = 24'h10_0000,
  parameter int          CLK_DIV      = 1,
  parameter int          WAKE_CYCLES  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] memWriteData,
  input  logic [3:0]  byteMask,
  output logic [31:0] memReadData,
  output logic        memReady,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    ST_WAKE, ST_WAKE_WAIT, ST_IDLE, ST_XFER, ST_DONE
  } state_e;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAKE_CYCLES - 1);

  state_e        state_q, state_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [6:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;

  // Write port is accepted electrically but has no function on a read-only window.
  logic unused_inputs;
  assign unused_inputs = ^{memWrite, memWriteData, byteMask};

  // Window decode: unsigned offset compare covers both ends of the window.
  logic [31:0] win_off;
  logic        hit;
  logic [23:0] flash_addr;
  assign win_off    = memAddress - BASE_ADDR;
  assign hit        = (win_off < WINDOW_BYTES);
  assign flash_addr = FLASH_OFFSET + {win_off[23:2], 2'b00};

  // Serial engine runs while CS is low and bits remain (8 for wake, 64 for a read).
  logic       tick;
  logic [6:0] last_bit;
  logic       shifting;
  assign tick     = (div_cnt_q == DIV_LAST);
  assign last_bit = (state_q == ST_WAKE) ? 7'd8 : 7'd64;
  assign shifting = !cs_n_q && (bit_cnt_q < last_bit) &&
                    ((state_q == ST_WAKE) || (state_q == ST_XFER));

  // State register plus all registered outputs and datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WAKE;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state: wake, settle, then serve hits; bit 64/65 are the CS-low hold before DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAKE:      if (!cs_n_q && (bit_cnt_q == 7'd8)) state_d = ST_WAKE_WAIT;
      ST_WAKE_WAIT: if (wait_cnt_q == WAIT_LAST) state_d = ST_IDLE;
      ST_IDLE:      if (memRead && hit) state_d = ST_XFER;
      ST_XFER:      if (bit_cnt_q == 7'd65) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_WAKE;
    endcase
  end

  // Outputs/datapath: load a frame on entry, shift MSB first, assemble the word little-endian.
  always_comb begin
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    case (state_q)
      ST_WAKE: begin
        if (cs_n_q) begin
          cs_n_d    = 1'b0;
          tx_d      = {8'hAB, 24'h0};
          mosi_d    = 1'b1;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end else if (bit_cnt_q == 7'd8) begin
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          wait_cnt_d = '0;
        end
      end
      ST_WAKE_WAIT: wait_cnt_d = wait_cnt_q + 1'b1;
      ST_IDLE: begin
        if (memRead && hit) begin
          cs_n_d    = 1'b0;
          tx_d      = {8'h03, flash_addr};
          mosi_d    = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      ST_XFER: begin
        if (bit_cnt_q == 7'd64) begin
          bit_cnt_d = 7'd65;
        end else if (bit_cnt_q == 7'd65) begin
          // CS rises two cycles after the last SCK fall, enough hold for CLK_DIV <= 2.
          cs_n_d  = 1'b1;
          rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (shifting) begin
      if (tick) begin
        div_cnt_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          if ((state_q == ST_XFER) && (bit_cnt_q >= 7'd32)) rx_d = {rx_q[30:0], spi_miso};
        end else begin
          // Cell boundary: SCK falls and the next bit goes out; zeros follow the command.
          sck_d     = 1'b0;
          bit_cnt_d = bit_cnt_q + 7'd1;
          tx_d      = {tx_q[30:0], 1'b0};
          mosi_d    = tx_q[30];
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  assign memReadData = rdata_q;
  assign memReady    = ready_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_flash_mmio.sv
// Bench for spi_flash_mmio: two instances (CLK_DIV 1 and 2) sharing one SPI flash model.
// Expected words come from a byte-addressed flash image and the window mapping rules.
// Only one instance is ever active on the SPI bus at a time.
module tb_spi_flash_mmio;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] WIN  = 32'h0010_0000;
  localparam logic [23:0] OFF  = 24'h10_0000;
  localparam int          WAKE = 24;

  logic        clk = 1'b0;
  logic        rst_n0 = 1'b1, rst_n1 = 1'b1;
  logic        rd0 = 1'b0, rd1 = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdat = '0;
  logic [3:0]  bmask = '0;
  logic        miso = 1'b0;
  wire  [31:0] rdata0, rdata1;
  wire         rdy0, rdy1, cs0, cs1, sck0, sck1, mosi0, mosi1;

  always #5 clk = ~clk;

  spi_flash_mmio #(.BASE_ADDR(BASE), .WINDOW_BYTES(WIN), .FLASH_OFFSET(OFF),
                   .CLK_DIV(1), .WAKE_CYCLES(WAKE)) dut0 (
    .clk(clk), .reset(rst_n0), .memAddress(addr), .memRead(rd0), .memWrite(wr),
    .memWriteData(wdat), .byteMask(bmask), .memReadData(rdata0), .memReady(rdy0),
    .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso));

  spi_flash_mmio #(.BASE_ADDR(BASE), .WINDOW_BYTES(WIN), .FLASH_OFFSET(OFF),
                   .CLK_DIV(2), .WAKE_CYCLES(WAKE)) dut1 (
    .clk(clk), .reset(rst_n1), .memAddress(addr), .memRead(rd1), .memWrite(wr),
    .memWriteData(wdat), .byteMask(bmask), .memReadData(rdata1), .memReady(rdy1),
    .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso));

  wire cs_any   = cs0 & cs1;
  wire sck_any  = sck0 | sck1;
  wire mosi_any = cs0 ? mosi1 : mosi0;

  // ---------------- flash model ----------------
  logic [7:0] fmem [int];
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (fmem.exists(int'(a))) return fmem[int'(a)];
    return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ 8'hC3;
  endfunction

  int          fbits = 0, ncs = 0, mosi_hi = 0;
  logic [31:0] fsr = '0, fcmd = '0;
  logic [7:0]  fbyte0 = '0;
  always @(negedge cs_any or posedge sck_any) begin
    if (!cs_any && sck_any) begin
      fsr = {fsr[30:0], mosi_any};
      fbits++;
      if (fbits == 8) fbyte0 = fsr[7:0];
      if (fbits == 32) fcmd = fsr;
      if (fbits > 32 && mosi_any) mosi_hi++;
    end else if (!cs_any) begin
      fbits = 0;
      ncs++;
    end
  end

  int         mk;
  logic [7:0] mcur;
  always @(negedge sck_any) begin
    if (!cs_any && fbits >= 32) begin
      mk   = fbits - 32;
      mcur = fbyte(fcmd[23:0] + 24'(mk / 8));
      miso = mcur[7 - (mk % 8)];
    end
  end

  // ---------------- bookkeeping ----------------
  int cyc = 0, nrdy0 = 0, nrdy1 = 0, wake_rise = 0, acc_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rdy0) nrdy0++;
    if (rdy1) nrdy1++;
  end

  int n_assert = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic cur_cs(input int g);   return (g == 0) ? cs0 : cs1; endfunction
  function automatic logic cur_rdy(input int g);  return (g == 0) ? rdy0 : rdy1; endfunction
  function automatic logic [31:0] cur_rdata(input int g); return (g == 0) ? rdata0 : rdata1; endfunction
  function automatic int cur_div(input int g);    return (g == 0) ? 1 : 2; endfunction
  task automatic set_rd(input int g, input logic v);
    if (g == 0) rd0 = v; else rd1 = v;
  endtask

  // Reference mapping: window offset, word aligned, relocated into flash.
  function automatic logic [23:0] ref_faddr(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return 24'(32'(OFF) + (o & ~32'd3));
  endfunction
  function automatic logic [31:0] ref_word(input logic [23:0] fa);
    return {fbyte(fa + 24'd3), fbyte(fa + 24'd2), fbyte(fa + 24'd1), fbyte(fa)};
  endfunction

  task automatic wait_wake(input int g, input string tag);
    bit ok;
    fbyte0 = '0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin step(1); if (cur_cs(g) == 1'b0) begin ok = 1; break; end end
    chk({tag, " wake cs low"}, 32'(ok), 32'd1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin step(1); if (cur_cs(g) == 1'b1) begin ok = 1; break; end end
    chk({tag, " wake cs high"}, 32'(ok), 32'd1);
    wake_rise = cyc;
    chk({tag, " wake opcode"}, 32'(fbyte0), 32'hAB);
    chk({tag, " wake bits"}, 32'(fbits), 32'd8);
  endtask

  task automatic do_read(input int g, input logic [31:0] a, input bit drop_early, input string tag);
    bit ok;
    int t0;
    logic [23:0] fa;
    logic [31:0] expw;
    fa = ref_faddr(a);
    expw = ref_word(fa);
    mosi_hi = 0;
    addr = a; wr = 1'($urandom_range(0, 1)); wdat = $urandom; bmask = 4'($urandom);
    set_rd(g, 1'b1);
    ok = 0;
    for (int i = 0; i < 400; i++) begin step(1); if (cur_cs(g) == 1'b0) begin ok = 1; break; end end
    chk({tag, " accepted"}, 32'(ok), 32'd1);
    t0 = cyc;
    acc_cyc = cyc;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (drop_early && i == 40) set_rd(g, 1'b0);
      if (cur_rdy(g)) begin ok = 1; break; end
    end
    set_rd(g, 1'b0);
    wr = 1'b0;
    chk({tag, " ready seen"}, 32'(ok), 32'd1);
    chk({tag, " latency"}, 32'(cyc - t0), 32'(2 + 128 * cur_div(g)));
    chk({tag, " data"}, cur_rdata(g), expw);
    chk({tag, " command"}, fcmd, {8'h03, fa});
    chk({tag, " mosi zero in data"}, 32'(mosi_hi), 32'd0);
    step(1);
    chk({tag, " single pulse"}, 32'(cur_rdy(g)), 32'd0);
    chk({tag, " data held"}, cur_rdata(g), expw);
    chk({tag, " cs idle"}, 32'(cur_cs(g)), 32'd1);
  endtask

  int          snap_ncs, snap_rdy, gap;
  logic [31:0] snap_dat;
  initial begin
    fmem[32'h100000] = 8'h11; fmem[32'h100001] = 8'h22;
    fmem[32'h100002] = 8'h33; fmem[32'h100003] = 8'h44;

    // Reset values on both instances.
    #1; rst_n0 = 1'b0; rst_n1 = 1'b0;
    step(2);
    chk("rst cs_n", 32'(cs0), 32'd1);
    chk("rst sck", 32'(sck0), 32'd0);
    chk("rst mosi", 32'(mosi0), 32'd0);
    chk("rst ready", 32'(rdy0), 32'd0);
    chk("rst rdata", rdata0, 32'd0);
    chk("rst cs_n div2", 32'(cs1), 32'd0 + 32'd1);
    chk("rst rdata div2", rdata1, 32'd0);

    // Request held through wake: must not be accepted before the settle time.
    addr = 32'h0; rd0 = 1'b1;
    rst_n0 = 1'b1;
    wait_wake(0, "boot");
    do_read(0, 32'h0000_0000, 1'b0, "first");
    gap = acc_cyc - wake_rise;
    chk("wake settle gap", 32'((gap >= WAKE) && (gap <= WAKE + 2)), 32'd1);
    chk("first word literal", rdata0, 32'h4433_2211);

    do_read(0, 32'h0000_0006, 1'b0, "unaligned");
    chk("unaligned cmd literal", fcmd, 32'h0310_0004);

    // Misses and writes never touch the bus.
    snap_ncs = ncs; snap_rdy = nrdy0; snap_dat = rdata0;
    addr = 32'hFFFF_FFF0; rd0 = 1'b1; step(300);
    addr = WIN;           step(100);
    rd0 = 1'b0; addr = 32'h0000_0010; wr = 1'b1; wdat = $urandom; bmask = 4'hF; step(200);
    wr = 1'b0;
    chk("miss no cs", 32'(ncs), 32'(snap_ncs));
    chk("miss no ready", 32'(nrdy0), 32'(snap_rdy));
    chk("miss data kept", rdata0, snap_dat);
    chk("miss cs high", 32'(cs0), 32'd1);

    // Window top edge, random reads, one with memRead dropped mid-transfer.
    do_read(0, WIN - 32'd1, 1'b0, "top");
    for (int i = 0; i < 5; i++)
      do_read(0, BASE + 32'($urandom_range(0, 32'h000F_FFFF)), (i == 2), "rand");

    // Reset in the data phase: CS rises at once, no ready, wake reruns.
    addr = BASE + 32'($urandom_range(0, 32'h000F_FFFF)); rd0 = 1'b1;
    for (int i = 0; i < 400; i++) begin step(1); if (!cs0) break; end
    step(80);
    snap_rdy = nrdy0;
    rst_n0 = 1'b0; rd0 = 1'b0;
    #1;
    chk("midrst cs_n", 32'(cs0), 32'd1);
    chk("midrst sck", 32'(sck0), 32'd0);
    chk("midrst ready", 32'(rdy0), 32'd0);
    step(5);
    rst_n0 = 1'b1;
    wait_wake(0, "rewake");
    chk("midrst no ready", 32'(nrdy0), 32'(snap_rdy));
    do_read(0, BASE + 32'($urandom_range(0, 32'h000F_FFFF)), 1'b0, "after rst");

    // CLK_DIV=2 instance: wake then back-to-back reads.
    rst_n1 = 1'b1;
    wait_wake(1, "div2");
    do_read(1, 32'h0000_0000, 1'b0, "div2 a");
    do_read(1, BASE + 32'($urandom_range(0, 32'h000F_FFFF)), 1'b0, "div2 b");
    chk("div2 cs0 quiet", 32'(cs0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_flash_mmio.md
# spi_flash_mmio

Read-only memory-mapped responder that services CPU word reads from an external SPI NOR flash (iCE40 configuration flash). It decodes the CPU memory bus within its own address window, runs a standard SPI READ (0x03) transaction per request, assembles the 32-bit little-endian word and signals completion with a one-cycle ready strobe. After reset it wakes the flash from deep power-down. This block is the planned replacement for BRAM as instruction/data store.

## Interface
- BASE_ADDR, 32'h0000_0000, first CPU byte address of the window
- WINDOW_BYTES, 32'h0010_0000, window size in bytes (power of two)
- FLASH_OFFSET, 24'h10_0000, flash byte address mapped to BASE_ADDR (skips bitstream)
- CLK_DIV, 1, SCK half-period in clk cycles (≥1)
- WAKE_CYCLES, 24, clk cycles CS high after release-from-power-down command

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- memAddress  in  32  CPU byte address
- memRead  in  1  read request level; held with memAddress stable until memReady
- memWrite  in  1  write strobe (ignored; block is read-only)
- memWriteData  in  32  ignored
- byteMask  in  4  ignored (full word always returned)
- memReadData  out  32  last word read; stable until next completion
- memReady  out  1  one-cycle pulse: memReadData valid for current request
- spi_cs_n  out  1  flash chip select, active low
- spi_sck  out  1  SPI clock, mode 0 (idle low)
- spi_mosi  out  1  data to flash, MSB first
- spi_miso  in  1  data from flash

## Operation
- Hit: memAddress in [BASE_ADDR, BASE_ADDR+WINDOW_BYTES-1]. Non-hit requests never start a transaction.
- Flash address = FLASH_OFFSET + ((memAddress − BASE_ADDR) & ~3), truncated to 24 bits; low two address bits ignored.
- States: WAKE → WAKE_WAIT → IDLE → XFER → DONE → IDLE.
- WAKE (entered on reset release): CS low, shift 8 bits 0xAB, CS high.
- WAKE_WAIT: CS high for WAKE_CYCLES cycles, then IDLE. Requests not accepted before IDLE (CPU keeps memRead held; accepted once IDLE reached).
- IDLE: if memRead & hit, latch flash address, go XFER.
- XFER: CS low; shift 32 bits out (0x03, addr[23:16], addr[15:8], addr[7:0]), then 32 bits in. MOSI driven 0 during data phase.
- Byte assembly: first received byte → memReadData[7:0], second → [15:8], third → [23:16], fourth → [31:24]; each byte MSB first.
- DONE: CS high, SCK low, memReadData updated, memReady=1 for exactly this cycle; next state IDLE.
- memWrite/memWriteData/byteMask have no effect in any state.
- memRead dropped mid-XFER: transaction completes normally; memReady still pulses.

## Timing
- Reset (async, immediate): spi_cs_n=1, spi_sck=0, spi_mosi=0, memReady=0, memReadData=0, state WAKE.
- All outputs registered.
- Bit cell = 2·CLK_DIV cycles: MOSI changes and SCK falls at cell start; SCK rises at mid-cell; MISO sampled on the clk edge where SCK rises.
- CS falls on the edge after acceptance; first SCK rise CLK_DIV cycles later; CS high ≥CLK_DIV cycles after last SCK fall.
- Read latency: memReady asserts exactly 2 + 128·CLK_DIV cycles after the accepting edge (130 for CLK_DIV=1).
- Back-to-back: new request accepted in the cycle after DONE at earliest; CS high ≥1 cycle between transactions.
- Reset asserted mid-XFER: CS deasserts immediately; no memReady; wake sequence reruns after release.

## Test plan
- Reset → cs_n=1, sck=0, memReady=0, memReadData=0; after release flash model sees byte 0xAB, then CS high for 24 cycles before any request accepted.
- Flash bytes 0x11,0x22,0x33,0x44 at 0x100000; memRead at 0x0000_0000 → model sees 03 10 00 00, memReadData=0x44332211, memReady single pulse 130 cycles after acceptance.
- memRead at 0x0000_0006 → flash address 0x100004 sent; data assembled little-endian.
- memRead at 0xFFFF_FFF0 and memWrite at 0x0000_0010 → cs_n stays 1, memReady never asserts, memReadData unchanged.
- Reset pulsed mid-data phase → cs_n high same cycle, no memReady, 0xAB resent after release; subsequent read correct.
- CLK_DIV=2 → SCK period 4 cycles, memReady after 258 cycles; two back-to-back reads both return correct words.
